// File: rtl/alu_issue_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_issue_if : decoded-instruction handshake from decoder into alu_issue    |
// | rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
interface alu_issue_if #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_alu_op;
    logic [REG_AW-1:0] in_rs1_idx;
    logic [REG_AW-1:0] in_rs2_idx;
    logic [DATA_W-1:0] in_rs1_data;
    logic [DATA_W-1:0] in_rs2_data;
    logic [DATA_W-1:0] in_imm;
    logic              in_use_imm;
    logic [REG_AW-1:0] in_rd_idx;
    logic              in_reg_write;
    logic              in_is_load;

    modport master (
        output in_valid, in_alu_op, in_rs1_idx, in_rs2_idx, in_rs1_data,
               in_rs2_data, in_imm, in_use_imm, in_rd_idx, in_reg_write,
               in_is_load,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_alu_op, in_rs1_idx, in_rs2_idx, in_rs1_data,
               in_rs2_data, in_imm, in_use_imm, in_rd_idx, in_reg_write,
               in_is_load,
        output in_ready
    );
endinterface
`default_nettype wire

// File: rtl/alu_issue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_issue : operand-issue stage with MEM/WB forwarding and load-use bubbles |
// | rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module alu_issue #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3,
    parameter int CNT_W  = 16
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    alu_issue_if.slave             dec,
    input  wire logic              stall,
    input  wire logic              flush,
    input  wire logic              mem_fwd_en,
    input  wire logic              mem_fwd_is_load,
    input  wire logic [REG_AW-1:0] mem_fwd_rd,
    input  wire logic [DATA_W-1:0] mem_fwd_data,
    input  wire logic              wb_fwd_en,
    input  wire logic [REG_AW-1:0] wb_fwd_rd,
    input  wire logic [DATA_W-1:0] wb_fwd_data,
    output logic                   out_valid,
    output logic [DATA_W-1:0]      alu_a,
    output logic [DATA_W-1:0]      alu_b,
    output logic [3:0]             alu_op,
    output logic [REG_AW-1:0]      out_rd_idx,
    output logic                   out_reg_write,
    output logic                   out_is_load,
    output logic [CNT_W-1:0]       bubble_cnt
);

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    logic              r_valid;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [3:0]        r_op;
    logic [REG_AW-1:0] r_rd;
    logic              r_reg_write;
    logic              r_is_load;
    logic [CNT_W-1:0]  r_bubble_cnt;

    logic [DATA_W-1:0] w_rs1_val;
    logic [DATA_W-1:0] w_rs2_val;
    logic [DATA_W-1:0] w_b_val;
    logic              w_hz;

    // MEM beats WB; a MEM load has no data yet, so it never forwards.
    function automatic logic [DATA_W-1:0] f_resolve(
        input logic [REG_AW-1:0] idx,
        input logic [DATA_W-1:0] rf_data,
        input logic              m_en,
        input logic              m_ld,
        input logic [REG_AW-1:0] m_rd,
        input logic [DATA_W-1:0] m_data,
        input logic              w_en,
        input logic [REG_AW-1:0] w_rd,
        input logic [DATA_W-1:0] w_data
    );
        logic [DATA_W-1:0] v;
        if (idx == '0)
            v = '0;
        else if (m_en && !m_ld && (m_rd == idx))
            v = m_data;
        else if (w_en && (w_rd == idx))
            v = w_data;
        else
            v = rf_data;
        return v;
    endfunction

    always_comb begin
        w_rs1_val = f_resolve(dec.in_rs1_idx, dec.in_rs1_data, mem_fwd_en,
                              mem_fwd_is_load, mem_fwd_rd, mem_fwd_data,
                              wb_fwd_en, wb_fwd_rd, wb_fwd_data);
        w_rs2_val = f_resolve(dec.in_rs2_idx, dec.in_rs2_data, mem_fwd_en,
                              mem_fwd_is_load, mem_fwd_rd, mem_fwd_data,
                              wb_fwd_en, wb_fwd_rd, wb_fwd_data);
        w_b_val   = dec.in_use_imm ? dec.in_imm : w_rs2_val;
        w_hz      = dec.in_valid && mem_fwd_en && mem_fwd_is_load &&
                    (mem_fwd_rd != '0) &&
                    ((mem_fwd_rd == dec.in_rs1_idx) ||
                     (!dec.in_use_imm && (mem_fwd_rd == dec.in_rs2_idx)));
    end

    assign dec.in_ready = !stall && !flush && !w_hz;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid      <= 1'b0;
            r_a          <= '0;
            r_b          <= '0;
            r_op         <= '0;
            r_rd         <= '0;
            r_reg_write  <= 1'b0;
            r_is_load    <= 1'b0;
            r_bubble_cnt <= '0;
        end else if (flush) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
        end else if (stall) begin
            r_valid <= r_valid;
        end else if (w_hz) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            if (r_bubble_cnt != c_cnt_max)
                r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
        end else if (dec.in_valid) begin
            r_valid     <= 1'b1;
            r_a         <= w_rs1_val;
            r_b         <= w_b_val;
            r_op        <= dec.in_alu_op;
            r_rd        <= dec.in_rd_idx;
            r_reg_write <= dec.in_reg_write;
            r_is_load   <= dec.in_is_load;
        end else begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
        end
    end

    assign out_valid     = r_valid;
    assign alu_a         = r_a;
    assign alu_b         = r_b;
    assign alu_op        = r_op;
    assign out_rd_idx    = r_rd;
    assign out_reg_write = r_reg_write;
    assign out_is_load   = r_is_load;
    assign bubble_cnt    = r_bubble_cnt;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_alu_issue : directed + random bench against a spec-level reference model |
// | rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_alu_issue;

    localparam int DATA_W = 16;
    localparam int REG_AW = 3;
    localparam int CNT_W  = 4;

    localparam logic [3:0] c_alu_add = 4'd0;
    localparam logic [3:0] c_alu_sub = 4'd1;
    localparam logic [3:0] c_alu_and = 4'd2;
    localparam logic [3:0] c_alu_or  = 4'd3;
    localparam logic [3:0] c_alu_slt = 4'd4;
    localparam logic [3:0] c_alu_sll = 4'd5;
    localparam logic [3:0] c_alu_srl = 4'd6;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              stall, flush;
    logic              mem_fwd_en, mem_fwd_is_load;
    logic [REG_AW-1:0] mem_fwd_rd;
    logic [DATA_W-1:0] mem_fwd_data;
    logic              wb_fwd_en;
    logic [REG_AW-1:0] wb_fwd_rd;
    logic [DATA_W-1:0] wb_fwd_data;
    logic              out_valid, out_reg_write, out_is_load;
    logic [DATA_W-1:0] alu_a, alu_b;
    logic [3:0]        alu_op;
    logic [REG_AW-1:0] out_rd_idx;
    logic [CNT_W-1:0]  bubble_cnt;

    alu_issue_if #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dec ();

    alu_issue #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .dec             (dec),
        .stall           (stall),
        .flush           (flush),
        .mem_fwd_en      (mem_fwd_en),
        .mem_fwd_is_load (mem_fwd_is_load),
        .mem_fwd_rd      (mem_fwd_rd),
        .mem_fwd_data    (mem_fwd_data),
        .wb_fwd_en       (wb_fwd_en),
        .wb_fwd_rd       (wb_fwd_rd),
        .wb_fwd_data     (wb_fwd_data),
        .out_valid       (out_valid),
        .alu_a           (alu_a),
        .alu_b           (alu_b),
        .alu_op          (alu_op),
        .out_rd_idx      (out_rd_idx),
        .out_reg_write   (out_reg_write),
        .out_is_load     (out_is_load),
        .bubble_cnt      (bubble_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference state: what the ALU inputs should show after the next edge.
    logic              m_valid, m_rw, m_ld;
    logic [DATA_W-1:0] m_a, m_b;
    logic [3:0]        m_op;
    logic [REG_AW-1:0] m_rd;
    int                m_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] ref_operand(input int idx, input logic [DATA_W-1:0] rf);
        if (idx == 0) return '0;
        if (mem_fwd_en && !mem_fwd_is_load && int'(mem_fwd_rd) == idx) return mem_fwd_data;
        if (wb_fwd_en && int'(wb_fwd_rd) == idx) return wb_fwd_data;
        return rf;
    endfunction

    function automatic bit ref_load_use();
        bit uses1, uses2;
        if (!dec.in_valid || !mem_fwd_en || !mem_fwd_is_load || mem_fwd_rd == 0) return 1'b0;
        uses1 = (mem_fwd_rd == dec.in_rs1_idx);
        uses2 = !dec.in_use_imm && (mem_fwd_rd == dec.in_rs2_idx);
        return uses1 || uses2;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_rw = 0; m_ld = 0; m_a = '0; m_b = '0; m_op = '0; m_rd = '0; m_cnt = 0;
    endtask

    task automatic idle();
        dec.in_valid = 0; dec.in_alu_op = '0; dec.in_rs1_idx = '0; dec.in_rs2_idx = '0;
        dec.in_rs1_data = '0; dec.in_rs2_data = '0; dec.in_imm = '0; dec.in_use_imm = 0;
        dec.in_rd_idx = '0; dec.in_reg_write = 0; dec.in_is_load = 0;
        stall = 0; flush = 0; mem_fwd_en = 0; mem_fwd_is_load = 0; mem_fwd_rd = '0;
        mem_fwd_data = '0; wb_fwd_en = 0; wb_fwd_rd = '0; wb_fwd_data = '0;
    endtask

    task automatic set_instr(input logic [3:0] op, input int rs1, input logic [15:0] d1,
                             input int rs2, input logic [15:0] d2, input bit use_imm,
                             input logic [15:0] imm, input int rd);
        dec.in_valid = 1; dec.in_alu_op = op;
        dec.in_rs1_idx = REG_AW'(rs1); dec.in_rs1_data = d1;
        dec.in_rs2_idx = REG_AW'(rs2); dec.in_rs2_data = d2;
        dec.in_use_imm = use_imm; dec.in_imm = imm;
        dec.in_rd_idx = REG_AW'(rd); dec.in_reg_write = 1; dec.in_is_load = 0;
    endtask

    // Called at posedge+1 with inputs already set; returns at the next posedge+1.
    task automatic step();
        bit hz;
        #1;
        hz = ref_load_use();
        chk("in_ready", dec.in_ready, !stall && !flush && !hz);
        if (flush) begin
            m_valid = 0; m_rw = 0;
        end else if (stall) begin
            // everything holds
        end else if (hz) begin
            m_valid = 0; m_rw = 0;
            if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
        end else if (dec.in_valid) begin
            m_valid = 1;
            m_a  = ref_operand(int'(dec.in_rs1_idx), dec.in_rs1_data);
            m_b  = dec.in_use_imm ? dec.in_imm : ref_operand(int'(dec.in_rs2_idx), dec.in_rs2_data);
            m_op = dec.in_alu_op; m_rd = dec.in_rd_idx;
            m_rw = dec.in_reg_write; m_ld = dec.in_is_load;
        end else begin
            m_valid = 0; m_rw = 0;
        end
        @(posedge clk);
        #1;
        chk("out_valid", out_valid, m_valid);
        chk("out_reg_write", out_reg_write, m_rw);
        chk("bubble_cnt", bubble_cnt, m_cnt);
        if (m_valid) begin
            chk("alu_a", alu_a, m_a);
            chk("alu_b", alu_b, m_b);
            chk("alu_op", alu_op, m_op);
            chk("out_rd_idx", out_rd_idx, m_rd);
            chk("out_is_load", out_is_load, m_ld);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_a"}, alu_a, 0);
        chk({tag, "_b"}, alu_b, 0);
        chk({tag, "_op"}, alu_op, 0);
        chk({tag, "_rd"}, out_rd_idx, 0);
        chk({tag, "_rw"}, out_reg_write, 0);
        chk({tag, "_ld"}, out_is_load, 0);
        chk({tag, "_cnt"}, bubble_cnt, 0);
    endtask

    initial begin
        idle();
        model_reset();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1;
        @(posedge clk); #1;

        // Plain ADD from the register file
        set_instr(c_alu_add, 1, 16'd5, 2, 16'd3, 0, 16'h0, 4);
        step();
        chk("add_a", alu_a, 16'd5);
        chk("add_b", alu_b, 16'd3);
        chk("add_op", alu_op, c_alu_add);

        // MEM and WB both target r3: MEM wins, then WB alone
        set_instr(c_alu_sub, 3, 16'h0001, 2, 16'h0002, 0, 16'h0, 5);
        mem_fwd_en = 1; mem_fwd_rd = 3; mem_fwd_data = 16'h1234;
        wb_fwd_en = 1; wb_fwd_rd = 3; wb_fwd_data = 16'hBEEF;
        step();
        chk("fwd_mem_a", alu_a, 16'h1234);
        mem_fwd_en = 0;
        step();
        chk("fwd_wb_a", alu_a, 16'hBEEF);

        // r0 reads zero regardless of file data or forwarding
        idle();
        set_instr(c_alu_or, 0, 16'hFFFF, 0, 16'hFFFF, 0, 16'h0, 1);
        mem_fwd_en = 1; mem_fwd_rd = 0; mem_fwd_data = 16'hAAAA;
        step();
        chk("r0_a", alu_a, 16'h0);

        // Load-use on rs2 inserts one bubble, then captures forwarded data
        idle();
        set_instr(c_alu_add, 1, 16'd1, 2, 16'd9, 0, 16'h0, 6);
        mem_fwd_en = 1; mem_fwd_is_load = 1; mem_fwd_rd = 2; mem_fwd_data = 16'hDEAD;
        step();
        chk("lu_cnt", bubble_cnt, 1);
        mem_fwd_is_load = 0; mem_fwd_data = 16'd7;
        step();
        chk("lu_b", alu_b, 16'd7);
        set_instr(c_alu_slt, 1, 16'd1, 2, 16'd9, 1, 16'h0042, 6);
        mem_fwd_is_load = 1;
        step();
        chk("lu_imm_b", alu_b, 16'h0042);

        // Stage an AND, stall three cycles, then flush under stall
        idle();
        set_instr(c_alu_and, 1, 16'hFF00, 0, 16'h0, 1, 16'h0F0F, 2);
        step();
        set_instr(c_alu_sll, 3, 16'h1111, 4, 16'h2222, 0, 16'h0, 7);
        stall = 1;
        repeat (3) step();
        chk("stall_a", alu_a, 16'hFF00);
        chk("stall_b", alu_b, 16'h0F0F);
        flush = 1;
        step();
        chk("flush_valid", out_valid, 0);

        // Saturate the bubble counter
        idle();
        set_instr(c_alu_srl, 4, 16'h8000, 1, 16'h0, 0, 16'h0, 3);
        mem_fwd_en = 1; mem_fwd_is_load = 1; mem_fwd_rd = 4;
        repeat (20) step();
        chk("sat_cnt", bubble_cnt, (1 << CNT_W) - 1);

        // Async reset with no clock edge
        idle();
        set_instr(c_alu_add, 5, 16'h5A5A, 6, 16'h0101, 0, 16'h0, 5);
        step();
        #2 rst_n = 0;
        #1 chk_all_zero("async_rst");
        model_reset();
        @(posedge clk); #1;
        rst_n = 1;

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            dec.in_valid     = ($urandom_range(0, 3) != 0);
            dec.in_alu_op    = 4'($urandom_range(0, 6));
            dec.in_rs1_idx   = REG_AW'($urandom);
            dec.in_rs2_idx   = REG_AW'($urandom);
            dec.in_rs1_data  = DATA_W'($urandom);
            dec.in_rs2_data  = DATA_W'($urandom);
            dec.in_imm       = DATA_W'($urandom);
            dec.in_use_imm   = ($urandom_range(0, 2) == 0);
            dec.in_rd_idx    = REG_AW'($urandom);
            dec.in_reg_write = 1'($urandom);
            dec.in_is_load   = ($urandom_range(0, 3) == 0);
            stall            = ($urandom_range(0, 9) == 0);
            flush            = ($urandom_range(0, 19) == 0);
            mem_fwd_en       = 1'($urandom);
            mem_fwd_is_load  = ($urandom_range(0, 3) == 0);
            mem_fwd_rd       = REG_AW'($urandom);
            mem_fwd_data     = DATA_W'($urandom);
            wb_fwd_en        = 1'($urandom);
            wb_fwd_rd        = REG_AW'($urandom);
            wb_fwd_data      = DATA_W'($urandom);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_issue.md
Name: alu_issue

Overview:
- Operand-issue stage directly upstream of the 16-bit ALU: registers decoded instruction fields and drives the ALU's a, b and alu_op inputs for one cycle per instruction.
- Resolves RAW hazards by forwarding from the MEM and WB stages.
- Inserts a bubble on load-use hazards.
- Supports pipeline stall/flush and counts hazard bubbles for performance debug.

Parameters:
- DATA_W, 16, operand width (matches ALU)
- REG_AW, 3, register index width (8 registers, r0 hardwired to zero)
- CNT_W, 16, width of bubble counter

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  decoded instruction present
- in_ready  out  1  stage accepts instruction this cycle
- in_alu_op  in  4  ALU opcode (ALU_ADD/SUB/AND/OR/SLT/SLL/SRL encodings from defines)
- in_rs1_idx  in  REG_AW  source register 1 index
- in_rs2_idx  in  REG_AW  source register 2 index
- in_rs1_data  in  DATA_W  register-file read data 1
- in_rs2_data  in  DATA_W  register-file read data 2
- in_imm  in  DATA_W  sign/zero-extended immediate from decoder
- in_use_imm  in  1  1: operand b = in_imm instead of rs2
- in_rd_idx  in  REG_AW  destination register
- in_reg_write  in  1  instruction writes rd
- in_is_load  in  1  instruction is a load
- stall  in  1  downstream stall: hold all outputs
- flush  in  1  discard staged and incoming instruction
- mem_fwd_en  in  1  MEM stage writes a register
- mem_fwd_is_load  in  1  MEM-stage instruction is a load (data not yet valid)
- mem_fwd_rd  in  REG_AW  MEM-stage destination
- mem_fwd_data  in  DATA_W  MEM-stage ALU result
- wb_fwd_en  in  1  WB stage writes a register
- wb_fwd_rd  in  REG_AW  WB-stage destination
- wb_fwd_data  in  DATA_W  WB write data
- out_valid  out  1  ALU inputs hold a valid instruction
- alu_a  out  DATA_W  ALU operand a
- alu_b  out  DATA_W  ALU operand b
- alu_op  out  4  ALU opcode
- out_rd_idx  out  REG_AW  destination forwarded to EX
- out_reg_write  out  1  rd write enable, qualified by out_valid
- out_is_load  out  1  load flag forwarded to EX
- bubble_cnt  out  CNT_W  load-use bubbles inserted, saturating

Behaviour:
- Reset (rst_n=0, async): all outputs registered; out_valid, alu_a, alu_b, alu_op, out_rd_idx, out_reg_write, out_is_load and bubble_cnt all 0.
- Operand selection, combinational, evaluated in the capture cycle, per source s in {rs1, rs2}:
  - idx==0 -> 0.
  - Else mem_fwd_en && !mem_fwd_is_load && mem_fwd_rd==idx -> mem_fwd_data.
  - Else wb_fwd_en && wb_fwd_rd==idx -> wb_fwd_data.
  - Else register-file data.
  - MEM has priority over WB.
- Operand routing: alu_a = resolved rs1; alu_b = in_use_imm ? in_imm : resolved rs2.
- Hazard: hz = in_valid && mem_fwd_en && mem_fwd_is_load && mem_fwd_rd!=0 && (mem_fwd_rd==rs1_idx || (!in_use_imm && mem_fwd_rd==rs2_idx)).
- in_ready = !stall && !flush && !hz (combinational).
- Per-cycle priority, highest first:
  1. flush: out_valid<=0; other outputs don't-care but held; input not consumed.
  2. stall: all outputs hold, bubble_cnt holds.
  3. hz: out_valid<=0; bubble_cnt++ (saturates at all-ones); input not consumed, so the decoder holds it.
  4. in_valid: capture; out_valid<=1 next edge. Latency is one cycle from acceptance to ALU inputs.
  5. Otherwise: out_valid<=0.
- Flush and hz in the same cycle: flush wins; no count.
- Stall and hz in the same cycle: stall wins; no count.
- out_reg_write driven low whenever out_valid is low.
- Back-to-back accepts with no stall give full throughput: one instruction per cycle.
- Reset asserted mid-operation clears state immediately; the first capture happens after the first edge following deassertion.

Test Plan:
- Reset, then in_valid with ALU_ADD, rs1=r1 (data 5), rs2=r2 (data 3), use_imm=0 -> next cycle out_valid=1, alu_a=5, alu_b=3, alu_op=ALU_ADD.
- rs1=r3 with mem_fwd_en=1, rd=3, data 0x1234, and wb_fwd_en=1, rd=3, data 0xBEEF -> alu_a=0x1234 (MEM wins); MEM disabled -> alu_a=0xBEEF.
- rs1=r0 with in_rs1_data=0xFFFF and mem_fwd_rd=0 enabled -> alu_a=0.
- Load-use case: mem_fwd_is_load=1, rd=2, incoming rs2=r2, use_imm=0 -> in_ready=0 and out_valid=0 for one cycle, bubble_cnt=1. Next cycle MEM no longer a load, data 7 -> capture, alu_b=7. Repeat with use_imm=1 -> no bubble.
- Stall held 3 cycles with a valid staged instruction (a=0xFF00, b=0x0F0F, ALU_AND) -> outputs unchanged, in_ready=0. Flush asserted with stall -> out_valid=0 next edge.
- Force 0xFFFF hazard cycles (or parameter CNT_W=4 with 20 hazards) -> bubble_cnt saturates at all-ones. Async rst_n pulse mid-stream -> all outputs 0 without a clock edge.
